mem_wb_stage: RTL and testbench

- MEM stage plus MEM/WB pipeline register; sits directly downstream of the EX/MEM register.
- Consumes the EX/MEM control and data outputs and runs the data-memory access over a registered req/ack handshake with variable latency.
- Holds the upstream pipeline with stall_o while the access is outstanding, then registers the writeback bundle for the WB stage.

---
 rtl/mem_wb_stage.sv | 117 +++++++++++
 tb/tb_mem_wb_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage with req/ack data-memory access and MEM/WB register
module mem_wb_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUdata_i,
  input  logic [31:0] MemWdata_i,
  input  logic [4:0]  RegWaddr_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ALUdata_o,
  output logic [4:0]  RegWaddr_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          mem_req_q, mem_we_q, err_q;
  logic [31:0]   mem_addr_q, mem_wdata_q;
  logic          reg_write_q, mem_to_reg_q;
  logic [31:0]   read_data_q, alu_data_q;
  logic [4:0]    reg_waddr_q;

  logic acc, timeout, done;

  assign acc     = MemRead_i | MemWrite_i;
  assign timeout = (state_q == ACCESS) && !mem_ack_i && (cnt_q == CW'(MAX_WAIT - 1));
  assign done    = (state_q == ACCESS) && (mem_ack_i || timeout);
  // Gated by reset so the upstream is released the moment reset is asserted.
  assign stall_o = start_i && (((state_q == IDLE) && acc) || ((state_q == ACCESS) && !done));

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      err_q        <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      read_data_q  <= '0;
      alu_data_q   <= '0;
      reg_waddr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc) begin
            state_q      <= ACCESS;
            mem_req_q    <= 1'b1;
            mem_we_q     <= MemWrite_i;
            mem_addr_q   <= ALUdata_i;
            mem_wdata_q  <= MemWdata_i;
            cnt_q        <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
          end else begin
            reg_write_q  <= RegWrite_i;
            mem_to_reg_q <= MemtoReg_i;
            alu_data_q   <= ALUdata_i;
            reg_waddr_q  <= RegWaddr_i;
            read_data_q  <= '0;
          end
        end
        ACCESS: begin
          if (done) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            reg_write_q  <= RegWrite_i;
            mem_to_reg_q <= MemtoReg_i;
            alu_data_q   <= ALUdata_i;
            reg_waddr_q  <= RegWaddr_i;
            // A timed-out access never sees an ack, so its data reads as zero.
            read_data_q  <= (mem_ack_i && !mem_we_q) ? mem_rdata_i : 32'd0;
            if (timeout) err_q <= 1'b1;
          end else begin
            cnt_q        <= cnt_q + 1'b1;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;
  assign RegWrite_o  = reg_write_q;
  assign MemtoReg_o  = mem_to_reg_q;
  assign ReadData_o  = read_data_q;
  assign ALUdata_o   = alu_data_q;
  assign RegWaddr_o  = reg_waddr_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - randomized self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

  localparam int MAX_WAIT = 15;

  logic        clk_i = 1'b0;
  logic        start_i;
  logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
  logic [31:0] ALUdata_i, MemWdata_i;
  logic [4:0]  RegWaddr_i;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        mem_req_o, mem_we_o, stall_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        RegWrite_o, MemtoReg_o;
  logic [31:0] ReadData_o, ALUdata_o;
  logic [4:0]  RegWaddr_o;

  int checks = 0;
  int failures = 0;

  logic        exp_err;
  logic [31:0] exp_alu, exp_rd;
  logic [4:0]  exp_waddr;

  mem_wb_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk_i), .start_i(start_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .ALUdata_i(ALUdata_i), .MemWdata_i(MemWdata_i), .RegWaddr_i(RegWaddr_i),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .stall_o(stall_o), .err_o(err_o),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .ReadData_o(ReadData_o), .ALUdata_o(ALUdata_o), .RegWaddr_o(RegWaddr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One instruction from EX/MEM; ack_dly = ACCESS cycles without ack before the ack
  // (ack_dly >= MAX_WAIT means the memory never answers).
  task automatic run_instr(input logic rw, input logic m2r, input logic rd, input logic wr,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic [4:0] waddr, input int ack_dly,
                           input logic [31:0] rdata);
    logic is_mem, is_store, tmo;
    int   n_acc, total;
    is_mem   = rd | wr;
    is_store = wr;
    tmo      = is_mem && (ack_dly >= MAX_WAIT);
    n_acc    = !is_mem ? 0 : (tmo ? MAX_WAIT : ack_dly + 1);
    total    = 1 + n_acc;
    RegWrite_i = rw; MemtoReg_i = m2r; MemRead_i = rd; MemWrite_i = wr;
    ALUdata_i = alu; MemWdata_i = wd; RegWaddr_i = waddr;
    for (int k = 0; k < total; k++) begin
      if (is_mem && !tmo && k == ack_dly + 1) begin
        mem_ack_i = 1'b1; mem_rdata_i = rdata;
      end else if (k == 0) begin
        mem_ack_i = $urandom_range(0, 1); mem_rdata_i = $urandom;
      end else begin
        mem_ack_i = 1'b0; mem_rdata_i = $urandom;
      end
      #1;
      chk("stall", stall_o, (k < total - 1) ? 1 : 0);
      chk("req", mem_req_o, (k >= 1) ? 1 : 0);
      if (k >= 1) begin
        chk("addr", mem_addr_o, alu);
        chk("we", mem_we_o, is_store);
        if (is_store) chk("wdata", mem_wdata_o, wd);
        chk("bubble_rw", RegWrite_o, 0);
        chk("bubble_m2r", MemtoReg_o, 0);
        chk("hold_alu", ALUdata_o, exp_alu);
        chk("hold_rd", ReadData_o, exp_rd);
        chk("hold_waddr", RegWaddr_o, exp_waddr);
      end
      @(posedge clk_i); #1;
    end
    mem_ack_i = 1'b0;
    exp_alu   = alu;
    exp_waddr = waddr;
    exp_rd    = (is_mem && !is_store && !tmo) ? rdata : 32'd0;
    if (tmo) exp_err = 1'b1;
    chk("wb_rw", RegWrite_o, rw);
    chk("wb_m2r", MemtoReg_o, m2r);
    chk("wb_alu", ALUdata_o, exp_alu);
    chk("wb_rd", ReadData_o, exp_rd);
    chk("wb_waddr", RegWaddr_o, exp_waddr);
    chk("req_done", mem_req_o, 0);
    chk("we_done", mem_we_o, 0);
    chk("err", err_o, exp_err);
    if (is_mem) chk("addr_kept", mem_addr_o, alu);
  endtask

  initial begin
    start_i = 1'b0;
    {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i} = '0;
    ALUdata_i = '0; MemWdata_i = '0; RegWaddr_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    exp_err = 1'b0; exp_alu = '0; exp_rd = '0; exp_waddr = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req", mem_req_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rw", RegWrite_o, 0);
    chk("rst_alu", ALUdata_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    start_i = 1'b1;
    @(posedge clk_i); #1;

    run_instr(1, 0, 0, 0, 32'h5, 32'h0, 5'd3, 0, 32'h0);
    run_instr(1, 1, 1, 0, 32'h100, 32'h0, 5'd7, 2, 32'hDEADBEEF);
    run_instr(0, 0, 0, 1, 32'h40, 32'h1234, 5'd0, 0, 32'h0);
    run_instr(1, 1, 1, 0, 32'h200, 32'h0, 5'd1, 0, 32'hA5A5_0001);
    run_instr(1, 1, 1, 0, 32'h204, 32'h0, 5'd2, 0, 32'hA5A5_0002);
    run_instr(1, 1, 1, 1, 32'h300, 32'h77, 5'd4, 1, 32'hFFFF_FFFF);
    run_instr(1, 1, 1, 0, 32'h400, 32'h0, 5'd5, MAX_WAIT - 1, 32'hCAFE_F00D);

    for (int i = 0; i < 60; i++) begin
      logic [1:0] kind;
      int dly;
      kind = 2'($urandom_range(0, 3));
      dly  = ($urandom_range(0, 7) == 0) ? $urandom_range(MAX_WAIT, MAX_WAIT + 2)
                                         : $urandom_range(0, 4);
      run_instr(1'($urandom), 1'($urandom), kind[0], kind[1], $urandom, $urandom,
                5'($urandom), dly, $urandom);
    end

    run_instr(1, 0, 1, 0, 32'h500, 32'h0, 5'd9, MAX_WAIT, 32'h1111_2222);
    run_instr(1, 0, 0, 0, 32'h9, 32'h0, 5'd10, 0, 32'h0);

    // Reset in the middle of an access, then a stray ack afterwards.
    RegWrite_i = 1; MemtoReg_i = 1; MemRead_i = 1; MemWrite_i = 0;
    ALUdata_i = 32'h600; RegWaddr_i = 5'd11;
    repeat (3) @(posedge clk_i);
    #1;
    chk("pre_rst_req", mem_req_o, 1);
    start_i = 1'b0;
    #1;
    chk("mid_rst_req", mem_req_o, 0);
    chk("mid_rst_stall", stall_o, 0);
    chk("mid_rst_err", err_o, 0);
    chk("mid_rst_rw", RegWrite_o, 0);
    chk("mid_rst_m2r", MemtoReg_o, 0);
    chk("mid_rst_rd", ReadData_o, 0);
    chk("mid_rst_alu", ALUdata_o, 0);
    chk("mid_rst_waddr", RegWaddr_o, 0);
    {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i} = '0;
    ALUdata_i = '0; RegWaddr_i = '0;
    @(posedge clk_i); #2;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1357_9BDF;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    chk("post_ack_rd", ReadData_o, 0);
    chk("post_ack_req", mem_req_o, 0);
    chk("post_ack_stall", stall_o, 0);
    chk("post_ack_err", err_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
